// File: rtl/mux_pkg.sv
// Shared parameters, types and the round-robin pick function
// for the arbitrated mux stage.
package mux_pkg;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = (N <= 1) ? 1 : $clog2(N);
    localparam int MAXN  = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAXN-1:0] req,
        input int              ptr,
        input int              n
    );
        pick_t p;
        int    j;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = 0; i < MAXN; i++) begin
            if (i < n && !p.found) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                if (req[j]) begin
                    p.found = 1'b1;
                    p.idx   = j;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector and
// priority pointer in, grant index and found flag out.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = mux_pkg::N,
    parameter int SELW = mux_pkg::SELW
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            found
);

    pick_t pick;

    // Scan from the pointer, first requester wins.
    always_comb begin
        pick  = rr_pick(MAXN'(req), 32'(ptr), N);
        grant = SELW'(pick.idx);
        found = pick.found;
    end

endmodule

// File: rtl/mux_rr_arb.sv
// Round-robin arbitrated N:1 mux stage with a registered
// payload/index output and valid/ready handshaking.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH = mux_pkg::WIDTH,
    parameter  int N     = mux_pkg::N,
    localparam int SELW  = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     valid_i,
    input  logic [WIDTH-1:0] data_i [N],
    output logic [N-1:0]     ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SELW-1:0]  sel_o,
    input  logic             ready_i
);

    out_state_t       state_q;
    out_state_t       state_d;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  sel_q;
    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  ptr_nxt;
    logic [SELW:0]    ptr_inc;
    logic [SELW-1:0]  grant;
    logic             found;
    logic             load_en;
    logic             take;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req   (valid_i),
        .ptr   (ptr_q),
        .grant (grant),
        .found (found)
    );

    assign load_en = (state_q == EMPTY) || ready_i;
    assign take    = found && load_en;

    // Next pointer is one past the grant; widened so g+1 == N wraps.
    always_comb begin
        ptr_inc = {1'b0, grant} + (SELW+1)'(1);
        ptr_nxt = ptr_inc[SELW-1:0];
        if (ptr_inc == (SELW+1)'(N)) ptr_nxt = '0;
    end

    // Output-register occupancy and the one-hot input accept.
    always_comb begin
        state_d = state_q;
        ready_o = '0;
        if (take) ready_o[grant] = 1'b1;
        unique case (state_q)
            EMPTY: if (take) state_d = FULL;
            FULL: begin
                if (take)         state_d = FULL;
                else if (ready_i) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Payload, index and pointer load on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else if (take) begin
            data_q <= data_i[grant];
            sel_q  <= grant;
            ptr_q  <= ptr_nxt;
        end
    end

    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;
    assign sel_o   = sel_q;

endmodule
